spongent_stream_ctrl: RTL and testbench



---
 rtl/spongent_ctrl_pkg.sv | 19 +
 rtl/spongent_stream_ctrl.sv | 139 +++++++++++++
 tb/tb_spongent_stream_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spongent_ctrl_pkg.sv
// Shared state encoding and padding helper for the Spongent stream sequencer.
package spongent_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT,
    ABSORB,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    PAD,
    SQUEEZE
  } spongent_ctrl_state_t;

  // Padding block: a single leading one, rest zero; valid for rate <= 64.
  function automatic logic [63:0] PAD_BLOCK(input int unsigned rate);
    return 64'd1 << (rate - 1);
  endfunction

endpackage

// File: rtl/spongent_stream_ctrl.sv
// Sequences message blocks, padding and squeeze through the Spongent core handshake.
// Start pulse one cycle after each accept; msg/dig stalls are unbounded and side-effect free.
module spongent_stream_ctrl
  import spongent_ctrl_pkg::*;
#(
  parameter int RATE        = 8,
  parameter int DIGEST_BITS = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            msg_valid,
  output logic            msg_ready,
  input  logic [RATE-1:0] msg_data,
  input  logic            msg_last,
  output logic            dig_valid,
  input  logic            dig_ready,
  output logic [RATE-1:0] dig_data,
  output logic            dig_last,
  output logic            hash_busy,
  output logic            core_reset,
  output logic            core_start_continue,
  output logic            core_msg_data_available,
  output logic [RATE-1:0] core_data_in,
  input  logic            core_busy,
  input  logic [RATE-1:0] core_data_out
);

  localparam int NBLK  = DIGEST_BITS / RATE;
  localparam int CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NBLK - 1);
  localparam logic [63:0]      PAD64    = PAD_BLOCK(RATE);
  localparam logic [RATE-1:0]  PAD_VAL  = PAD64[RATE-1:0];

  spongent_ctrl_state_t state_q, state_d;
  logic             last_seen_q, last_seen_d;
  logic             pad_done_q, pad_done_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [RATE-1:0]  data_q, data_d;
  logic             msa_q, msa_d;
  logic             hash_busy_q, hash_busy_d;
  logic             msg_ready_q, dig_valid_q, dig_last_q, start_q, init_q;

  always_comb begin
    state_d     = state_q;
    last_seen_d = last_seen_q;
    pad_done_d  = pad_done_q;
    blk_cnt_d   = blk_cnt_q;
    data_d      = data_q;
    msa_d       = msa_q;
    hash_busy_d = hash_busy_q;
    unique case (state_q)
      INIT: begin
        last_seen_d = 1'b0;
        pad_done_d  = 1'b0;
        blk_cnt_d   = '0;
        state_d     = ABSORB;
      end
      ABSORB: begin
        if (msg_valid && msg_ready_q) begin
          data_d      = msg_data;
          msa_d       = 1'b1;
          last_seen_d = msg_last;
          hash_busy_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT_HI;
      WAIT_HI: if (core_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!core_busy) begin
          if (msa_q && !last_seen_q)     state_d = ABSORB;
          else if (msa_q && !pad_done_q) state_d = PAD;
          else                           state_d = SQUEEZE;
        end
      end
      PAD: begin
        data_d     = PAD_VAL;
        msa_d      = 1'b1;
        pad_done_d = 1'b1;
        state_d    = ISSUE;
      end
      SQUEEZE: begin
        if (dig_valid_q && dig_ready) begin
          if (blk_cnt_q == LAST_BLK) begin
            hash_busy_d = 1'b0;
            state_d     = INIT;
          end else begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
            msa_d     = 1'b0;
            state_d   = ISSUE;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      last_seen_q <= 1'b0;
      pad_done_q  <= 1'b0;
      blk_cnt_q   <= '0;
      data_q      <= '0;
      msa_q       <= 1'b0;
      hash_busy_q <= 1'b0;
      msg_ready_q <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_last_q  <= 1'b0;
      start_q     <= 1'b0;
      init_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      last_seen_q <= last_seen_d;
      pad_done_q  <= pad_done_d;
      blk_cnt_q   <= blk_cnt_d;
      data_q      <= data_d;
      msa_q       <= msa_d;
      hash_busy_q <= hash_busy_d;
      msg_ready_q <= (state_d == ABSORB);
      dig_valid_q <= (state_d == SQUEEZE);
      dig_last_q  <= (state_d == SQUEEZE) && (blk_cnt_d == LAST_BLK);
      start_q     <= (state_d == ISSUE);
      init_q      <= (state_d == INIT);
    end
  end

  assign msg_ready               = msg_ready_q;
  assign dig_valid               = dig_valid_q;
  assign dig_last                = dig_last_q;
  assign dig_data                = core_data_out;
  assign hash_busy               = hash_busy_q;
  assign core_reset              = reset | init_q;
  assign core_start_continue     = start_q;
  assign core_msg_data_available = msa_q;
  assign core_data_in            = data_q;

endmodule

// File: tb/tb_spongent_stream_ctrl.sv
// Bench for spongent_stream_ctrl with a behavioural sponge core and busy-delay model.
module tb_spongent_stream_ctrl;

  typedef logic [7:0] byte_q_t[$];
  localparam int LIM = 20000;

  logic       clk = 1'b0;
  logic       reset;
  logic       msg_valid, msg_ready, msg_last;
  logic [7:0] msg_data;
  logic       dig_valid, dig_ready, dig_last;
  logic [7:0] dig_data;
  logic       hash_busy, core_reset, core_start_continue, core_msg_data_available;
  logic [7:0] core_data_in, core_data_out;
  logic       core_busy;

  int tests = 0;
  int fails = 0;
  int bp = 0;
  int busy_len = 3;

  always #5 clk = ~clk;

  spongent_stream_ctrl #(.RATE(8), .DIGEST_BITS(128)) dut (
    .clk(clk), .reset(reset),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last),
    .hash_busy(hash_busy), .core_reset(core_reset),
    .core_start_continue(core_start_continue),
    .core_msg_data_available(core_msg_data_available),
    .core_data_in(core_data_in), .core_busy(core_busy), .core_data_out(core_data_out)
  );

  function automatic logic [31:0] mix(input logic [31:0] a, input logic [7:0] d);
    return ((a ^ {24'd0, d}) * 32'h0100_0193) + 32'h9E37_79B9;
  endfunction

  function automatic logic [7:0] fold(input logic [31:0] a);
    return a[31:24] ^ a[15:8] ^ a[7:0];
  endfunction

  // Expected digest: absorb every block, absorb one pad block, then 16 outputs with squeezes between.
  function automatic logic [127:0] ref_digest(input byte_q_t m);
    logic [31:0]  a;
    logic [127:0] d;
    a = '0;
    d = '0;
    foreach (m[i]) a = mix(a, m[i]);
    a = mix(a, 8'h80);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) a = mix(a, 8'h5A);
      d = {d[119:0], fold(a)};
    end
    return d;
  endfunction

  // Behavioural core: permutes on start, busy for busy_len cycles, then exposes its rate byte.
  logic [31:0] m_acc;
  int          m_cnt;
  always @(posedge clk or posedge core_reset) begin
    if (core_reset) begin
      m_acc <= '0; core_busy <= 1'b0; m_cnt <= 0; core_data_out <= '0;
    end else if (core_start_continue) begin
      m_acc     <= mix(m_acc, core_msg_data_available ? core_data_in : 8'h5A);
      core_busy <= 1'b1;
      m_cnt     <= busy_len;
    end else if (core_busy) begin
      if (m_cnt <= 1) begin
        core_busy     <= 1'b0;
        core_data_out <= fold(m_acc);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  initial begin
    dig_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      dig_ready = (bp == 2) ? 1'b0 : (bp == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int start_cnt = 0, init_cnt = 0;
  int timing_err = 0, ready_err = 0, stall_err = 0, rise_err = 0, hb_err = 0;
  logic p_msg_hs, p_start, p_dv, p_dr, p_dl, p_busy, pp_busy, p_last_hs;
  logic [7:0] p_dd;
  logic [7:0] dq[$];
  logic       lq[$];

  always @(negedge clk) begin
    if (reset) begin
      p_msg_hs = 0; p_start = 0; p_dv = 0; p_dr = 0; p_dl = 0;
      p_busy = 0; pp_busy = 0; p_last_hs = 0; p_dd = '0;
    end else begin
      if (core_start_continue) start_cnt++;
      if (core_reset) init_cnt++;
      if (p_msg_hs && !core_start_continue) timing_err++;
      if (p_start && core_start_continue) timing_err++;
      if (msg_ready && (dig_valid || core_start_continue || core_busy || core_reset)) ready_err++;
      if (p_dv && !p_dr && (!dig_valid || dig_data !== p_dd || dig_last !== p_dl)) stall_err++;
      if (dig_valid && !p_dv && !(!p_busy && pp_busy)) rise_err++;
      if (p_last_hs && (hash_busy || !core_reset)) hb_err++;
      if (p_msg_hs && !hash_busy) hb_err++;
      if (dig_valid && dig_ready) begin
        dq.push_back(dig_data);
        lq.push_back(dig_last);
      end
      pp_busy = p_busy; p_busy = core_busy;
      p_msg_hs = msg_valid & msg_ready; p_start = core_start_continue;
      p_dv = dig_valid; p_dr = dig_ready; p_dl = dig_last; p_dd = dig_data;
      p_last_hs = dig_valid & dig_ready & dig_last;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_blocks(input byte_q_t m, input int gap_max, input string tag);
    int n, g, worst;
    worst = 0;
    @(posedge clk); #1;
    foreach (m[i]) begin
      g = $urandom_range(0, gap_max);
      repeat (g) begin @(posedge clk); #1; end
      msg_valid = 1'b1; msg_data = m[i]; msg_last = (i == m.size() - 1);
      n = 0;
      while (n <= LIM) begin
        @(negedge clk);
        if (msg_ready) break;
        n++;
      end
      if (n > worst) worst = n;
      @(posedge clk); #1;
      msg_valid = 1'b0; msg_last = 1'b0; msg_data = 8'($urandom);
      if (worst > LIM) break;
    end
    chk({tag, "_accept_in_time"}, 128'(worst <= LIM), 128'(1));
  endtask

  task automatic run_hash(input byte_q_t m, input int gap_max, input int bsy, input int bpm,
                          input string tag, output logic [127:0] dig);
    int n;
    logic [15:0] lbits;
    busy_len = bsy; bp = bpm;
    dq.delete(); lq.delete();
    start_cnt = 0; init_cnt = 0;
    chk({tag, "_busy_idle"}, 128'(hash_busy), 128'(0));
    send_blocks(m, gap_max, tag);
    chk({tag, "_busy_active"}, 128'(hash_busy), 128'(1));
    n = 0;
    while (dq.size() < 16 && n < LIM) begin @(negedge clk); n++; end
    while (!msg_ready && n < LIM) begin @(negedge clk); n++; end
    chk({tag, "_done_in_time"}, 128'(n < LIM), 128'(1));
    dig = '0; lbits = '0;
    foreach (dq[i]) dig = {dig[119:0], dq[i]};
    foreach (lq[i]) lbits = {lbits[14:0], lq[i]};
    chk({tag, "_digest"}, dig, ref_digest(m));
    chk({tag, "_dig_count"}, 128'(dq.size()), 128'(16));
    chk({tag, "_last_flags"}, 128'(lbits), 128'(16'h0001));
    chk({tag, "_start_pulses"}, 128'(start_cnt), 128'(m.size() + 16));
    chk({tag, "_init_pulse"}, 128'(init_cnt), 128'(1));
    chk({tag, "_busy_cleared"}, 128'(hash_busy), 128'(0));
  endtask

  initial begin
    byte_q_t m;
    logic [127:0] d0, d1;
    int n;
    reset = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl_outs", 128'({msg_ready, dig_valid, dig_last, hash_busy,
                               core_start_continue, core_msg_data_available}), 128'(0));
    chk("rst_core_data_in", 128'(core_data_in), 128'(0));
    chk("rst_core_reset", 128'(core_reset), 128'(1));
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("init_core_reset", 128'(core_reset), 128'(1));
    chk("init_no_ready", 128'(msg_ready), 128'(0));
    @(negedge clk);
    chk("absorb_ready", 128'(msg_ready), 128'(1));
    chk("absorb_core_reset_low", 128'(core_reset), 128'(0));

    m = {8'h00};
    run_hash(m, 0, 3, 0, "one_blk", d0);
    m = {8'h61, 8'h62, 8'h63};
    run_hash(m, 0, 3, 0, "abc", d0);
    run_hash(m, 5, 3, 0, "abc_gap", d1);
    chk("abc_gap_same", d1, d0);
    run_hash(m, 0, 10, 0, "busy10", d1);
    chk("busy10_same", d1, d0);

    for (int k = 0; k < 4; k++) begin
      m.delete();
      repeat ($urandom_range(1, 6)) m.push_back(8'($urandom));
      run_hash(m, 3, $urandom_range(1, 10), 1, $sformatf("rnd%0d", k), d1);
    end

    // Abort a hash while the sixth digest block is stalled on the sink.
    m = {8'h5C, 8'hA7};
    busy_len = 4; bp = 0; dq.delete(); lq.delete();
    send_blocks(m, 0, "abort");
    n = 0;
    while (dq.size() < 5 && n < LIM) begin @(negedge clk); n++; end
    bp = 2;
    while (!(dig_valid && !dig_ready && dq.size() == 5) && n < LIM) begin @(negedge clk); n++; end
    chk("abort_reached_blk5", 128'(n < LIM), 128'(1));
    @(posedge clk); #1; reset = 1'b1; #1;
    chk("abort_ctrl_outs", 128'({msg_ready, dig_valid, dig_last, hash_busy,
                                 core_start_continue, core_msg_data_available}), 128'(0));
    chk("abort_core_data_in", 128'(core_data_in), 128'(0));
    chk("abort_core_reset", 128'(core_reset), 128'(1));
    repeat (3) @(posedge clk); #1; reset = 1'b0; bp = 0;
    repeat (2) @(posedge clk); #1;
    m = {8'h3E};
    run_hash(m, 0, 5, 0, "after_abort", d1);

    m = {8'h01, 8'h02};
    run_hash(m, 0, 2, 0, "b2b_first", d0);
    m = {8'hF0};
    run_hash(m, 0, 2, 1, "b2b_second", d1);

    chk("start_timing", 128'(timing_err), 128'(0));
    chk("ready_only_absorb", 128'(ready_err), 128'(0));
    chk("stall_stable", 128'(stall_err), 128'(0));
    chk("valid_after_busy_fall", 128'(rise_err), 128'(0));
    chk("hash_busy_edges", 128'(hb_err), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
